exu_div: RTL and testbench

- Iterative radix-2 restoring divider in the EXU, directly downstream of idu1.
- Consumes the registered idu1_out_t bundle when div=1 and legal=1, and computes RISC-V DIV/DIVU/REM/REMU.
- Drives exu_div_busy back to idu1 for stall generation, and produces one writeback request toward the EXU writeback mux.
- Blocking unit: only one divide is in flight at a time.

---
 rtl/exu_div_pkg.sv | 47 ++++
 rtl/dff_rst.sv | 23 ++
 rtl/dff_rst_en_flush.sv | 27 ++
 rtl/div_step.sv | 27 ++
 rtl/exu_div.sv | 217 +++++++++++++++++++++
 tb/tb_exu_div.sv | 237 +++++++++++++++++++++++
 6 files changed

// File: rtl/exu_div_pkg.sv
// Shared types and constants for the EXU iterative divider.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package exu_div_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 6;
    localparam int unsigned CNT_W = $clog2(XLEN);

    // Architectural results for the two cases that skip the iteration.
    localparam logic [XLEN-1:0] DIV_BY_ZERO_QUO = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] DIV_OVF_QUO     = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    // Subset of the idu1 issue bundle seen by the divider.
    typedef struct packed {
        logic              div;
        logic              rem;
        logic              unsign;
        logic              legal;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [4:0]        rd_addr;
        logic [TAG_W-1:0]  instr_tag;
    } idu1_out_t;

    // Per-operation bookkeeping captured at accept time.
    typedef struct packed {
        logic [4:0]        rd_addr;
        logic [TAG_W-1:0]  instr_tag;
        logic              rem_sel;
        logic              neg_quo;
        logic              neg_rem;
    } div_meta_t;

    // Two's-complement magnitude when the value is to be treated as negative.
    function automatic logic [XLEN-1:0] abs_if_neg(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/dff_rst.sv
// Plain register with asynchronous active-low reset to RST_VAL.
// Latency: 1 cycle.
// Backpressure: none; loads every cycle.
// Ports: clk, rst_n, i_d (next value), o_q (registered value).
module dff_rst #(
    parameter int unsigned   W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  i_d,
    output logic [W-1:0]  o_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= RST_VAL;
        end else begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/dff_rst_en_flush.sv
// Register with async active-low reset, load enable and synchronous flush to RST_VAL.
// Latency: 1 cycle.
// Backpressure: holds value when i_en is low; i_flush wins over i_en.
// Ports: clk, rst_n, i_en, i_flush, i_d, o_q.
module dff_rst_en_flush #(
    parameter int unsigned   W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic          i_flush,
    input  logic [W-1:0]  i_d,
    output logic [W-1:0]  o_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= RST_VAL;
        end else if (i_flush) begin
            o_q <= RST_VAL;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
// Latency: combinational.
// Backpressure: none.
// Ports: i_rem (partial remainder, < divisor), i_dvd_bit, i_divisor, o_rem, o_quo_bit.
module div_step
    import exu_div_pkg::*;
#(
    parameter int unsigned W = XLEN
) (
    input  logic [W-1:0]  i_rem,
    input  logic          i_dvd_bit,
    input  logic [W-1:0]  i_divisor,
    output logic [W-1:0]  o_rem,
    output logic          o_quo_bit
);

    logic [W:0]    w_shift;
    logic [W-1:0]  w_sub_lo;

    assign w_shift   = {i_rem, i_dvd_bit};
    assign o_quo_bit = (w_shift >= {1'b0, i_divisor});
    // When the subtract succeeds the true difference is below the divisor, so
    // the low W bits of the modular difference are the exact result.
    assign w_sub_lo  = w_shift[W-1:0] - i_divisor;
    assign o_rem     = o_quo_bit ? w_sub_lo : w_shift[W-1:0];

endmodule

// File: rtl/exu_div.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU, one op in flight.
// Latency: XLEN/BITS_PER_CYCLE+2 cycles to writeback strobe; divide-by-zero/overflow in 1 cycle.
// Backpressure: none on output; div_busy stalls idu1, new op accepted only in IDLE or DONE.
// Ports: clk, rst_n, idu1_out (issue bundle), pipe_flush (kills same-cycle issue),
//        div_busy (CALC/FIXUP), div_wb_data/div_wb_rd_addr/div_wb_instr_tag, div_wb_rd_wr_en (1-cycle strobe).
module exu_div
    import exu_div_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  idu1_out_t         idu1_out,
    input  logic              pipe_flush,
    output logic              div_busy,
    output logic [XLEN-1:0]   div_wb_data,
    output logic [4:0]        div_wb_rd_addr,
    output logic [TAG_W-1:0]  div_wb_instr_tag,
    output logic              div_wb_rd_wr_en
);

    localparam int unsigned        CALC_CYC = XLEN / BITS_PER_CYCLE;
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(CALC_CYC - 1);

    // ---------------------------------------------------------------
    // Issue decode
    // ---------------------------------------------------------------
    logic             w_accept;
    logic             w_signed;
    logic             w_rs1_neg;
    logic             w_rs2_neg;
    logic             w_div0;
    logic             w_ovf;
    logic             w_special;
    logic [XLEN-1:0]  w_special_res;
    logic [XLEN-1:0]  w_abs1;
    logic [XLEN-1:0]  w_abs2;
    div_meta_t        w_meta_d;

    div_state_t       r_state;
    logic [1:0]       r_state_bits;
    div_state_t       w_state_nxt;

    assign w_accept  = ((r_state == IDLE) || (r_state == DONE)) &
                       idu1_out.div & idu1_out.legal & ~pipe_flush;
    assign w_signed  = ~idu1_out.unsign;
    assign w_rs1_neg = w_signed & idu1_out.rs1_data[XLEN-1];
    assign w_rs2_neg = w_signed & idu1_out.rs2_data[XLEN-1];
    assign w_abs1    = abs_if_neg(w_rs1_neg, idu1_out.rs1_data);
    assign w_abs2    = abs_if_neg(w_rs2_neg, idu1_out.rs2_data);

    assign w_div0    = (idu1_out.rs2_data == '0);
    assign w_ovf     = w_signed & (idu1_out.rs1_data == DIV_OVF_QUO) & (idu1_out.rs2_data == '1);
    assign w_special = w_div0 | w_ovf;

    // Divide-by-zero takes priority: its remainder is the raw dividend.
    always_comb begin
        w_special_res = DIV_OVF_QUO;
        if (idu1_out.rem) begin
            w_special_res = w_div0 ? idu1_out.rs1_data : '0;
        end else begin
            w_special_res = w_div0 ? DIV_BY_ZERO_QUO : DIV_OVF_QUO;
        end
    end

    assign w_meta_d.rd_addr   = idu1_out.rd_addr;
    assign w_meta_d.instr_tag = idu1_out.instr_tag;
    assign w_meta_d.rem_sel   = idu1_out.rem;
    assign w_meta_d.neg_quo   = w_rs1_neg ^ w_rs2_neg;
    assign w_meta_d.neg_rem   = w_rs1_neg;

    // ---------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ---------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;

    dff_rst #(.W(2), .RST_VAL(2'(IDLE))) u_state_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_state_nxt),
        .o_q   (r_state_bits)
    );
    assign r_state = div_state_t'(r_state_bits);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? DONE : CALC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = FIXUP;
                end
            end
            FIXUP:   w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Busy drops in DONE so idu1 releases its stall on the writeback cycle.
    always_comb begin
        div_busy        = 1'b0;
        div_wb_rd_wr_en = 1'b0;
        case (r_state)
            CALC, FIXUP: div_busy        = 1'b1;
            DONE:        div_wb_rd_wr_en = 1'b1;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Iteration datapath
    // ---------------------------------------------------------------
    logic                                 w_calc;
    logic [XLEN-1:0]                      r_quo;      // dividend shifting out, quotient shifting in
    logic [XLEN-1:0]                      r_divisor;
    logic [XLEN-1:0]                      r_rem_acc;
    div_meta_t                            r_meta;
    logic [BITS_PER_CYCLE:0][XLEN-1:0]    w_rem_chain;
    logic [BITS_PER_CYCLE-1:0]            w_qbits;
    logic [XLEN-1:0]                      w_quo_nxt;
    logic [CNT_W-1:0]                     w_cnt_d;
    logic [XLEN-1:0]                      w_quo_d;

    assign w_calc = (r_state == CALC);

    assign w_rem_chain[0] = r_rem_acc;
    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        div_step #(.W(XLEN)) u_div_step (
            .i_rem     (w_rem_chain[g]),
            .i_dvd_bit (r_quo[XLEN-1-g]),
            .i_divisor (r_divisor),
            .o_rem     (w_rem_chain[g+1]),
            .o_quo_bit (w_qbits[BITS_PER_CYCLE-1-g])
        );
    end

    assign w_quo_nxt = {r_quo[XLEN-1-BITS_PER_CYCLE:0], w_qbits};
    assign w_cnt_d   = w_accept ? CNT_LOAD : (r_cnt - CNT_W'(1));
    assign w_quo_d   = w_accept ? w_abs1 : w_quo_nxt;

    dff_rst_en_flush #(.W(CNT_W)) u_cnt_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_accept | w_calc),
        .i_flush (1'b0),
        .i_d     (w_cnt_d),
        .o_q     (r_cnt)
    );

    dff_rst_en_flush #(.W(XLEN)) u_quo_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_accept | w_calc),
        .i_flush (1'b0),
        .i_d     (w_quo_d),
        .o_q     (r_quo)
    );

    dff_rst_en_flush #(.W(XLEN)) u_divisor_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_accept),
        .i_flush (1'b0),
        .i_d     (w_abs2),
        .o_q     (r_divisor)
    );

    // The partial remainder starts from zero for every new operation.
    dff_rst_en_flush #(.W(XLEN)) u_rem_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_calc),
        .i_flush (w_accept),
        .i_d     (w_rem_chain[BITS_PER_CYCLE]),
        .o_q     (r_rem_acc)
    );

    dff_rst_en_flush #(.W($bits(div_meta_t))) u_meta_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_accept),
        .i_flush (1'b0),
        .i_d     (w_meta_d),
        .o_q     (r_meta)
    );

    // ---------------------------------------------------------------
    // Sign fixup and writeback register
    // ---------------------------------------------------------------
    logic             w_fixup;
    logic [XLEN-1:0]  w_fix_res;
    logic [XLEN-1:0]  w_wb_d;

    assign w_fixup   = (r_state == FIXUP);
    assign w_fix_res = r_meta.rem_sel ? abs_if_neg(r_meta.neg_rem, r_rem_acc)
                                      : abs_if_neg(r_meta.neg_quo, r_quo);
    assign w_wb_d    = w_fixup ? w_fix_res : w_special_res;

    dff_rst_en_flush #(.W(XLEN)) u_wb_data_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_fixup | (w_accept & w_special)),
        .i_flush (1'b0),
        .i_d     (w_wb_d),
        .o_q     (div_wb_data)
    );

    assign div_wb_rd_addr   = r_meta.rd_addr;
    assign div_wb_instr_tag = r_meta.instr_tag;

endmodule

// File: tb/tb_exu_div.sv
module tb_exu_div;
    import exu_div_pkg::*;

    localparam int CALC_CYC = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    idu1_out_t         idu1_out;
    logic              pipe_flush;
    logic              div_busy;
    logic [XLEN-1:0]   div_wb_data;
    logic [4:0]        div_wb_rd_addr;
    logic [TAG_W-1:0]  div_wb_instr_tag;
    logic              div_wb_rd_wr_en;

    int n_checks = 0;
    int n_fail   = 0;

    exu_div #(.BITS_PER_CYCLE(1)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .idu1_out         (idu1_out),
        .pipe_flush       (pipe_flush),
        .div_busy         (div_busy),
        .div_wb_data      (div_wb_data),
        .div_wb_rd_addr   (div_wb_rd_addr),
        .div_wb_instr_tag (div_wb_instr_tag),
        .div_wb_rd_wr_en  (div_wb_rd_wr_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: RISC-V M-extension divide semantics in plain arithmetic.
    function automatic logic [31:0] model_div(input logic rm, input logic us,
                                              input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (b == 32'd0) return rm ? a : 32'hFFFF_FFFF;
        if (us) return rm ? (a % b) : (a / b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rm ? 32'd0 : 32'h8000_0000;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return rm ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic bit model_special(input logic us, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!us && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic drive_inputs(input logic dv, input logic lg, input logic rm, input logic us,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic [TAG_W-1:0] tg, input logic fl);
        idu1_out.div       = dv;
        idu1_out.legal     = lg;
        idu1_out.rem       = rm;
        idu1_out.unsign    = us;
        idu1_out.rs1_data  = a;
        idu1_out.rs2_data  = b;
        idu1_out.rd_addr   = rd;
        idu1_out.instr_tag = tg;
        pipe_flush         = fl;
    endtask

    task automatic drive_idle();
        drive_inputs(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
                     5'($urandom), TAG_W'($urandom), 1'b0);
    endtask

    // A legal divide the DUT must ignore because it is busy (or flushed).
    task automatic drive_junk(input logic fl);
        drive_inputs(1'b1, 1'b1, 1'($urandom), 1'($urandom), $urandom, $urandom,
                     5'($urandom), TAG_W'($urandom), fl);
    endtask

    // Called just before the accept edge; returns in the strobe cycle.
    task automatic wait_wb(input string nm, input logic [31:0] exp_data, input logic [4:0] exp_rd,
                           input logic [TAG_W-1:0] exp_tag, input int exp_cyc, input int exp_busy,
                           input int flush_at);
        int cyc;
        int busy_n;
        bit got;
        busy_n = 0;
        got    = 0;
        @(posedge clk); #1;
        cyc = 1;
        while (!got && cyc <= 80) begin
            if (div_busy) busy_n++;
            if (div_wb_rd_wr_en) begin
                got = 1;
                drive_idle();
                chk({nm, "_cycle"}, 32'(cyc), 32'(exp_cyc));
                chk({nm, "_data"}, div_wb_data, exp_data);
                chk({nm, "_rd"}, 32'(div_wb_rd_addr), 32'(exp_rd));
                chk({nm, "_tag"}, 32'(div_wb_instr_tag), 32'(exp_tag));
            end else begin
                if (cyc < exp_cyc) drive_junk(cyc == flush_at);
                else drive_idle();
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk({nm, "_strobe_seen"}, 32'(got), 32'd1);
        chk({nm, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    endtask

    task automatic run_op(input string nm, input logic rm, input logic us,
                          input logic [31:0] a, input logic [31:0] b, input int flush_at);
        logic [4:0] rd;
        logic [TAG_W-1:0] tg;
        bit sp;
        rd = 5'($urandom_range(1, 31));
        tg = TAG_W'($urandom_range(1, 63));
        sp = model_special(us, a, b);
        drive_inputs(1'b1, 1'b1, rm, us, a, b, rd, tg, 1'b0);
        wait_wb(nm, model_div(rm, us, a, b), rd, tg, sp ? 1 : CALC_CYC + 2,
                sp ? 0 : CALC_CYC + 1, flush_at);
        @(posedge clk); #1;
        chk({nm, "_one_shot"}, 32'(div_wb_rd_wr_en), 32'd0);
        chk({nm, "_idle_busy"}, 32'(div_busy), 32'd0);
    endtask

    // Presents an instruction that must not be accepted and watches for activity.
    task automatic expect_ignored(input string nm, input logic dv, input logic lg, input logic fl);
        drive_inputs(dv, lg, 1'b0, 1'b0, 32'd100, 32'd7, 5'd3, TAG_W'(5), fl);
        @(posedge clk); #1;
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            chk({nm, "_busy"}, 32'(div_busy), 32'd0);
            chk({nm, "_strobe"}, 32'(div_wb_rd_wr_en), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] a, b;
        logic rm, us;
        int kind, fl_at, strobes;

        rst_n = 1'b0;
        drive_inputs(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, '0, 1'b0);
        #2;
        chk("rst_busy", 32'(div_busy), 32'd0);
        chk("rst_wr_en", 32'(div_wb_rd_wr_en), 32'd0);
        chk("rst_data", div_wb_data, 32'd0);
        chk("rst_rd", 32'(div_wb_rd_addr), 32'd0);
        chk("rst_tag", 32'(div_wb_instr_tag), 32'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op("div_100_7",   1'b0, 1'b0, 32'd100, 32'd7, -1);
        run_op("rem_100_7",   1'b1, 1'b0, 32'd100, 32'd7, -1);
        run_op("div_m7_2",    1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, -1);
        run_op("rem_m7_2",    1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, -1);
        run_op("divu_big_2",  1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, -1);
        run_op("div_5_0",     1'b0, 1'b0, 32'd5, 32'd0, -1);
        run_op("remu_5_0",    1'b1, 1'b1, 32'd5, 32'd0, -1);
        run_op("div_ovf",     1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("rem_ovf",     1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("divu_no_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("rem_neg_neg", 1'b1, 1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, -1);
        run_op("div_flush",   1'b0, 1'b0, 32'd12345, 32'd17, 10);

        // Instructions that must be ignored
        expect_ignored("flush_at_issue", 1'b1, 1'b1, 1'b1);
        expect_ignored("illegal",        1'b1, 1'b0, 1'b0);
        expect_ignored("not_div",        1'b0, 1'b1, 1'b0);

        // Back-to-back: second op presented in the first op's DONE cycle
        drive_inputs(1'b1, 1'b1, 1'b0, 1'b0, 32'd1000, 32'd9, 5'd11, TAG_W'(21), 1'b0);
        wait_wb("b2b_first", 32'd111, 5'd11, TAG_W'(21), CALC_CYC + 2, CALC_CYC + 1, -1);
        drive_inputs(1'b1, 1'b1, 1'b1, 1'b0, 32'd1000, 32'd9, 5'd12, TAG_W'(22), 1'b0);
        wait_wb("b2b_second", 32'd1, 5'd12, TAG_W'(22), CALC_CYC + 2, CALC_CYC + 1, -1);
        @(posedge clk); #1;
        chk("b2b_one_shot", 32'(div_wb_rd_wr_en), 32'd0);

        // Asynchronous reset in CALC cycle 10
        drive_inputs(1'b1, 1'b1, 1'b0, 1'b0, 32'd1000, 32'd7, 5'd17, TAG_W'(33), 1'b0);
        @(posedge clk); #1;
        drive_idle();
        repeat (9) begin
            @(posedge clk); #1;
        end
        chk("mid_rst_busy_before", 32'(div_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(div_busy), 32'd0);
        chk("mid_rst_wr_en", 32'(div_wb_rd_wr_en), 32'd0);
        chk("mid_rst_data", div_wb_data, 32'd0);
        chk("mid_rst_rd", 32'(div_wb_rd_addr), 32'd0);
        chk("mid_rst_tag", 32'(div_wb_instr_tag), 32'd0);
        #3 rst_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (div_wb_rd_wr_en || div_busy) strobes++;
        end
        chk("mid_rst_no_activity", 32'(strobes), 32'd0);
        run_op("div_9_3_after_rst", 1'b0, 1'b0, 32'd9, 32'd3, -1);

        // Randomised operations against the model
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            rm = 1'($urandom);
            us = 1'($urandom);
            a = $urandom;
            b = $urandom;
            case (kind)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
                3: b = 32'($signed(-$urandom_range(1, 50)));
                4: b = $urandom_range(1, 255);
                default: ;
            endcase
            fl_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, CALC_CYC) : -1;
            run_op("rnd", rm, us, a, b, fl_at);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
